// File: rtl/conv_pkg.sv
// Shared types and default sizing for the systolic convolution array sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StStream,
    StDrain,
    StWaitY,
    StDone
  } conv_state_e;

  localparam int unsigned ConvK     = 3;
  localparam int unsigned ConvLat   = 3;
  localparam int unsigned ConvDataW = 8;
  localparam int unsigned ConvAccW  = 20;
  localparam int unsigned ConvLenW  = 10;

endpackage

// File: rtl/conv_array_ctrl_if.sv
// Bundles the job, weight, sample, array and result signals of the convolution sequencer.
interface conv_array_ctrl_if
  import conv_pkg::*;
#(
  parameter int unsigned K      = ConvK,
  parameter int unsigned DATA_W = ConvDataW,
  parameter int unsigned ACC_W  = ConvAccW,
  parameter int unsigned LEN_W  = ConvLenW
) ();

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_ready;
  logic              x_valid;
  logic [DATA_W-1:0] x_data;
  logic              x_ready;
  logic              arr_en;
  logic [DATA_W-1:0] arr_x;
  logic [K-1:0]      arr_w_sel;
  logic [DATA_W-1:0] arr_w_data;
  logic [ACC_W-1:0]  arr_y;
  logic              y_valid;
  logic [ACC_W-1:0]  y_data;
  logic              y_ready;

  // Controller side.
  modport slave (
    input  start, len, w_valid, w_data, x_valid, x_data, arr_y, y_ready,
    output busy, done, w_ready, x_ready, arr_en, arr_x, arr_w_sel, arr_w_data, y_valid, y_data
  );

  // Environment side: job source, streams, array and result consumer.
  modport master (
    output start, len, w_valid, w_data, x_valid, x_data, arr_y, y_ready,
    input  busy, done, w_ready, x_ready, arr_en, arr_x, arr_w_sel, arr_w_data, y_valid, y_data
  );

endinterface

// File: rtl/conv_tag_delay.sv
// Enable-gated 1-bit delay line that tracks which array steps carry a valid result.
module conv_tag_delay #(
  parameter int unsigned Lat = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic [Lat-1:0] tag_q, tag_d;

  always_comb begin
    tag_d = tag_q;
    if (en_i) begin
      tag_d[0] = d_i;
      for (int i = 1; i < Lat; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign q_o = tag_q[Lat-1];

endmodule

// File: rtl/conv_array_ctrl.sv
// Sequencer for a K-tap systolic convolution array: loads weights, streams samples, drains results.
module conv_array_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned K      = ConvK,
  parameter int unsigned LAT    = ConvLat,
  parameter int unsigned DATA_W = ConvDataW,
  parameter int unsigned ACC_W  = ConvAccW,
  parameter int unsigned LEN_W  = ConvLenW
) (
  input logic               clk,
  input logic               rst,
  conv_array_ctrl_if.slave  ctrl_io
);

  localparam int unsigned WidxW = $clog2(K);

  conv_state_e       state_q, state_d;
  logic [WidxW-1:0]  widx_q, widx_d;
  logic [LEN_W-1:0]  sidx_q, sidx_d;
  logic [LEN_W-1:0]  drain_q, drain_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              y_valid_q, y_valid_d;
  logic [ACC_W-1:0]  y_data_q, y_data_d;

  logic              stall;
  logic              w_ready;
  logic              x_ready;
  logic              arr_en;
  logic [DATA_W-1:0] arr_x;
  logic [K-1:0]      arr_w_sel;
  logic [DATA_W-1:0] arr_w_data;
  logic              tag_in;
  logic              tag_out;
  logic              capture;

  // A held result blocks every array step so the output slot is always free on capture.
  assign stall = y_valid_q & ~ctrl_io.y_ready;

  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    sidx_d     = sidx_q;
    drain_d    = drain_q;
    len_d      = len_q;
    w_ready    = 1'b0;
    x_ready    = 1'b0;
    arr_en     = 1'b0;
    arr_x      = '0;
    arr_w_sel  = '0;
    arr_w_data = '0;
    tag_in     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctrl_io.start) begin
          len_d   = ctrl_io.len;
          widx_d  = '0;
          sidx_d  = '0;
          drain_d = '0;
          state_d = StLoadW;
        end
      end
      StLoadW: begin
        w_ready = 1'b1;
        if (ctrl_io.w_valid) begin
          arr_w_sel  = K'(1) << widx_q;
          arr_w_data = ctrl_io.w_data;
          widx_d     = widx_q + 1'b1;
          if (widx_q == WidxW'(K - 1)) begin
            state_d = (len_q >= LEN_W'(K)) ? StStream : StDone;
          end
        end
      end
      StStream: begin
        x_ready = ~stall;
        arr_en  = ctrl_io.x_valid & ~stall;
        if (arr_en) begin
          arr_x  = ctrl_io.x_data;
          // The first K-1 steps only prime the array; later steps complete a window.
          tag_in = (sidx_q >= LEN_W'(K - 1));
          sidx_d = sidx_q + 1'b1;
          if (sidx_q == len_q - 1'b1) begin
            drain_d = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        arr_en = ~stall;
        if (arr_en) begin
          drain_d = drain_q + 1'b1;
          if (drain_q == LEN_W'(LAT - 1)) begin
            state_d = StWaitY;
          end
        end
      end
      StWaitY: begin
        if (!y_valid_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  conv_tag_delay #(
    .Lat (LAT)
  ) u_tag_delay (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (arr_en),
    .d_i   (tag_in),
    .q_o   (tag_out)
  );

  assign capture = arr_en & tag_out;

  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    if (capture) begin
      y_valid_d = 1'b1;
      y_data_d  = ctrl_io.arr_y;
    end else if (y_valid_q && ctrl_io.y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      widx_q    <= '0;
      sidx_q    <= '0;
      drain_q   <= '0;
      len_q     <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      widx_q    <= widx_d;
      sidx_q    <= sidx_d;
      drain_q   <= drain_d;
      len_q     <= len_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
    end
  end

  assign ctrl_io.busy       = (state_q != StIdle);
  assign ctrl_io.done       = (state_q == StDone);
  assign ctrl_io.w_ready    = w_ready;
  assign ctrl_io.x_ready    = x_ready;
  assign ctrl_io.arr_en     = arr_en;
  assign ctrl_io.arr_x      = arr_x;
  assign ctrl_io.arr_w_sel  = arr_w_sel;
  assign ctrl_io.arr_w_data = arr_w_data;
  assign ctrl_io.y_valid    = y_valid_q;
  assign ctrl_io.y_data     = y_data_q;

endmodule

// File: tb/tb_conv_array_ctrl.sv
// Bench for conv_array_ctrl: behavioural K-tap array plus a windowed-sum reference model.
module tb_conv_array_ctrl;
  import conv_pkg::*;

  localparam int unsigned K      = ConvK;
  localparam int unsigned LAT    = ConvLat;
  localparam int unsigned DATA_W = ConvDataW;
  localparam int unsigned ACC_W  = ConvAccW;
  localparam int unsigned LEN_W  = ConvLenW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_array_ctrl_if #(
    .K      (K),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) ctrl_if ();

  conv_array_ctrl #(
    .K      (K),
    .LAT    (LAT),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (ctrl_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int wgt[K];
  int xin[$];

  // Behavioural array: weight registers, sample window, LAT-step result pipeline.
  logic [DATA_W-1:0] wreg[K];
  logic [DATA_W-1:0] hist[K];
  logic [ACC_W-1:0]  pipe[LAT];

  initial begin
    for (int i = 0; i < K; i++) begin
      wreg[i] = '0;
      hist[i] = '0;
    end
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
  end

  always @(posedge clk) begin : arr_model
    longint s;
    s = 0;
    for (int k = 0; k < K; k++) begin
      if (ctrl_if.arr_w_sel[k]) wreg[k] <= ctrl_if.arr_w_data;
    end
    if (ctrl_if.arr_en) begin
      for (int k = 0; k < K; k++) begin
        if (K - 1 - k == 0) s = s + longint'(wreg[k]) * longint'(ctrl_if.arr_x);
        else s = s + longint'(wreg[k]) * longint'(hist[K-2-k]);
      end
      hist[0] <= ctrl_if.arr_x;
      for (int i = 1; i < K; i++) hist[i] <= hist[i-1];
      pipe[0] <= s[ACC_W-1:0];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign ctrl_if.arr_y = pipe[LAT-1];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ready_mode: 0 always ready, 1 hold off 4 stalled cycles at first result, 2 random.
  // bubble_mode: 0 dense, 1 alternate, 2 random. abort_after >= 0 resets after that many samples.
  task automatic run_job(input int len_v, input int ready_mode, input int bubble_mode,
                         input int abort_after, input bit start_mid);
    int     wq[$];
    int     xq[$];
    longint exp_q[$];
    longint got_q[$];
    longint acc;
    int     en_cnt, done_cnt, stall_cnt, x_acc;
    int     last_w_cyc, last_acc_cyc, done_cyc;
    int     wq_pre;
    bit     released, xtog, finished, aborted;

    for (int n = 0; n + K <= len_v; n++) begin
      acc = 0;
      for (int k = 0; k < K; k++) acc += longint'(wgt[k]) * longint'(xin[n+k]);
      exp_q.push_back(acc);
    end
    for (int k = 0; k < K; k++) wq.push_back(wgt[k]);
    for (int i = 0; i < len_v; i++) xq.push_back(xin[i]);
    en_cnt = 0; done_cnt = 0; stall_cnt = 0; x_acc = 0;
    last_w_cyc = -100; last_acc_cyc = -100; done_cyc = -100;
    released = (ready_mode != 1); xtog = 1'b0; finished = 1'b0; aborted = 1'b0;

    @(posedge clk); #1;
    ctrl_if.start = 1'b1;
    ctrl_if.len   = LEN_W'(len_v);
    @(posedge clk); #1;
    ctrl_if.start = 1'b0;

    for (int c = 0; c < 400; c++) begin
      ctrl_if.w_valid = (wq.size() > 0);
      ctrl_if.w_data  = (wq.size() > 0) ? DATA_W'(wq[0]) : DATA_W'($urandom);
      xtog = ~xtog;
      ctrl_if.x_valid = (xq.size() > 0) &&
                        (bubble_mode == 0 ? 1'b1 :
                         bubble_mode == 1 ? xtog : 1'($urandom_range(0, 1)));
      ctrl_if.x_data  = (xq.size() > 0) ? DATA_W'(xq[0]) : DATA_W'($urandom);
      ctrl_if.y_ready = (ready_mode == 0) ? 1'b1 :
                        (ready_mode == 1) ? released : ($urandom_range(0, 3) != 0);
      if (start_mid && x_acc == 1) begin
        ctrl_if.start = 1'b1;
        ctrl_if.len   = LEN_W'(7);
      end else begin
        ctrl_if.start = 1'b0;
      end
      @(negedge clk);
      wq_pre = wq.size();
      if (ctrl_if.busy && wq_pre > 0) check_eq("load_x_ready", ctrl_if.x_ready, 0);
      if (ctrl_if.busy && wq_pre == 0) check_eq("w_ready_off", ctrl_if.w_ready, 0);
      if (ctrl_if.w_valid && ctrl_if.w_ready) begin
        void'(wq.pop_front());
        last_w_cyc = c;
      end
      if (ctrl_if.x_valid && ctrl_if.x_ready) begin
        void'(xq.pop_front());
        x_acc++;
      end
      if (ctrl_if.arr_en) en_cnt++;
      if (ctrl_if.y_valid && !ctrl_if.y_ready) begin
        check_eq("stall_x_ready", ctrl_if.x_ready, 0);
        check_eq("stall_arr_en", ctrl_if.arr_en, 0);
        check_eq("stall_y_hold", ctrl_if.y_data,
                 (got_q.size() < exp_q.size()) ? exp_q[got_q.size()] : -1);
        if (!released) begin
          stall_cnt++;
          if (stall_cnt == 4) released = 1'b1;
        end
      end
      if (ctrl_if.y_valid && ctrl_if.y_ready) begin
        got_q.push_back(longint'(ctrl_if.y_data));
        last_acc_cyc = c;
      end
      if (ctrl_if.done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == done_cyc + 1) begin
        check_eq("busy_after_done", ctrl_if.busy, 0);
        finished = 1'b1;
        break;
      end
      if (abort_after >= 0 && x_acc == abort_after) begin
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end

    ctrl_if.start   = 1'b0;
    ctrl_if.w_valid = 1'b0;
    ctrl_if.x_valid = 1'b0;
    ctrl_if.y_ready = 1'b1;

    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_busy", ctrl_if.busy, 0);
      check_eq("abort_y_valid", ctrl_if.y_valid, 0);
      check_eq("abort_done", ctrl_if.done, 0);
    end else begin
      check_eq("job_finished", finished, 1);
      check_eq("n_results", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        check_eq($sformatf("y[%0d]", i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
      end
      check_eq("arr_en_count", en_cnt, (len_v >= int'(K)) ? len_v + int'(LAT) : 0);
      check_eq("done_count", done_cnt, 1);
      if (exp_q.size() > 0) check_eq("done_latency", done_cyc - last_acc_cyc, 2);
      else check_eq("short_done_latency", done_cyc - last_w_cyc, 1);
    end
  endtask

  initial begin
    int len_v;
    ctrl_if.start   = 1'b0;
    ctrl_if.len     = '0;
    ctrl_if.w_valid = 1'b0;
    ctrl_if.w_data  = '0;
    ctrl_if.x_valid = 1'b0;
    ctrl_if.x_data  = '0;
    ctrl_if.y_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", ctrl_if.busy, 0);
    check_eq("rst_done", ctrl_if.done, 0);
    check_eq("rst_w_ready", ctrl_if.w_ready, 0);
    check_eq("rst_x_ready", ctrl_if.x_ready, 0);
    check_eq("rst_arr_en", ctrl_if.arr_en, 0);
    check_eq("rst_arr_w_sel", ctrl_if.arr_w_sel, 0);
    check_eq("rst_y_valid", ctrl_if.y_valid, 0);
    check_eq("rst_y_data", ctrl_if.y_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    wgt = '{1, 2, 3};
    xin = {1, 2, 3, 4, 5};
    run_job(5, 0, 0, -1, 1'b0);
    run_job(5, 1, 0, -1, 1'b0);
    run_job(5, 0, 1, -1, 1'b0);
    xin = {4, 6};
    run_job(2, 0, 0, -1, 1'b0);
    xin = {1, 2, 3, 4, 5};
    run_job(5, 0, 0, 3, 1'b0);
    wgt = '{0, 0, 1};
    xin = {7, 8, 9};
    run_job(3, 0, 0, -1, 1'b0);
    wgt = '{1, 2, 3};
    xin = {1, 2, 3, 4, 5};
    run_job(5, 0, 0, -1, 1'b1);

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < K; k++) wgt[k] = $urandom_range(0, 255);
      len_v = $urandom_range(0, 9);
      xin = {};
      for (int i = 0; i < len_v; i++) xin.push_back($urandom_range(0, 255));
      run_job(len_v, 2, 2, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_array_ctrl.md
Name: conv_array_ctrl

Overview:
- Sequencer for a 1-D systolic convolution array built from K chained MAC processing elements.
- Per job, it loads K weights into the array, then streams `len` input samples through it.
- It then drains the array pipeline and emits the `len-K+1` valid convolution results on a ready/valid output.
- It owns all array step enables, so backpressure on either side stalls the whole array coherently.

Parameters:
- K, 3, number of taps / PEs in the array (≥2)
- LAT, 3, array steps from presenting the last sample of a window on arr_x to that window's result on arr_y (≥1)
- DATA_W, 8, sample and weight width
- ACC_W, 20, result width
- LEN_W, 10, width of the job length field

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  job start pulse; honoured only in IDLE
- len  in  LEN_W  number of input samples; sampled on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- w_valid  in  1  weight-stream valid
- w_data  in  DATA_W  weight value; tap 0 first
- w_ready  out  1  weight-stream ready
- x_valid  in  1  sample-stream valid
- x_data  in  DATA_W  input sample
- x_ready  out  1  sample-stream ready
- arr_en  out  1  advance the array one step (PE clock enable)
- arr_x  out  DATA_W  sample into PE0
- arr_w_sel  out  K  one-hot weight-register write select
- arr_w_data  out  DATA_W  weight write data
- arr_y  in  ACC_W  result from the last PE
- y_valid  out  1  result valid
- y_data  out  ACC_W  result
- y_ready  in  1  result consumer ready

Behaviour:
- Reset values: all outputs 0; state IDLE; counters, tag line and len register cleared.
- rst mid-job aborts immediately to IDLE. No done is issued and any pending y is dropped.
- States:
  - IDLE: start=1 latches len, clears counters, and goes to LOAD_W. start while busy is ignored.
  - LOAD_W:
    - w_ready=1.
    - On w_valid&&w_ready: arr_w_sel=one-hot(widx) and arr_w_data=w_data in the same cycle (combinational); widx++.
    - After the transfer with widx=K-1: go to STREAM if len≥K, else go to DONE with zero outputs.
  - STREAM:
    - stall = y_valid&&!y_ready; x_ready = !stall.
    - arr_en = x_valid&&x_ready; arr_x = x_data (combinational; 0 when arr_en=0).
    - Each step j (0-based) pushes tag_in=(j≥K-1) into the tag line; sidx++.
    - After step j=len-1, go to DRAIN.
  - DRAIN: arr_en=!stall and arr_x=0, for exactly LAT steps, then go to WAIT_Y.
  - WAIT_Y: remain until y_valid=0, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Tag line:
  - LAT-deep shift register, shifted only on arr_en.
  - On a step where tag[LAT-1]=1 (checked before the shift), capture y_data<=arr_y and set y_valid<=1.
  - The stall rule guarantees the output slot is free on every step.
- Output handshake:
  - y_valid&&y_ready clears y_valid unless the same cycle captures a new result; in that case y_valid stays 1 with the new data (back-to-back at 1/cycle).
  - y_data holds stable while y_valid&&!y_ready.
- Counts: exactly len-K+1 results per job, in window order. len<K yields none.
- Counter widths: widx is clog2(K) bits; sidx and the drain counter are LEN_W bits. No wrap within a legal job.
- Latency: done follows acceptance of the last result by 2 cycles (WAIT_Y→DONE, DONE→IDLE; busy drops on the IDLE cycle).
- w_valid during STREAM and x_valid during LOAD_W are ignored; their ready signals are low.

Decomposition:
- Shared package conv_pkg: state enum (IDLE, LOAD_W, STREAM, DRAIN, WAIT_Y, DONE), default K, LAT, DATA_W and ACC_W constants.
- Sub-module: conv_tag_delay. A LAT-deep enable-gated 1-bit shift register; reused for any future array-latency tracking.

Test Plan:
- Bench drives the controller into a behavioural K=3, LAT=3 array model computing y_n=Σ w[k]·x[n+k].
- Basic job: weights 1,2,3; x=1,2,3,4,5; len=5; y_ready=1 -> y=14,20,26 in order, then done pulse; arr_en asserted exactly 5+3 times.
- Backpressure: same job with y_ready low for 4 cycles at the first result -> x_ready and arr_en low throughout; outputs still 14,20,26; y_data stable while stalled.
- Input bubbles: x_valid toggling 1,0,1,0… -> identical results; arr_en only on accepted samples.
- Short job: len=2 after loading 3 weights -> no y_valid and no arr_en; done 1 cycle after the third weight.
- Reset mid-STREAM after 3 samples, then a new job with weights 0,0,1 and x=7,8,9 (len=3) -> busy=0 the cycle after rst; the new job outputs the single value 9; no stale result.
- start asserted during STREAM -> ignored; len unchanged; job completes normally.
